// File: rtl/uart_tx_scheduler_if.sv
// Byte handshake between the message scheduler and the uart_tx transmitter.
// The scheduler is the master: it strobes tx_en with tx_din and watches tx_busy.
interface uart_tx_scheduler_if;
  logic       tx_en;
  logic [7:0] tx_din;
  logic       tx_busy;

  modport master (output tx_en, output tx_din, input tx_busy);
  modport slave  (input tx_en, input tx_din, output tx_busy);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between alarm, RX-echo and periodic time-report messages.
// Define TX_ECHO_EN to enable the RX echo source; without it rx_done/rx_data are ignored.
module uart_tx_scheduler #(
  parameter int REPORT_DIV   = 1,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk1sec,
  input  logic                      report_en,
  input  logic                      ring_alarm,
  input  logic                      rx_done,
  input  logic [7:0]                rx_data,
  input  logic [7:0]                hour,
  input  logic [7:0]                min,
  input  logic [7:0]                sec,
  uart_tx_scheduler_if.master       tx,
  output logic                      msg_busy,
  output logic [1:0]                src
);

  localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_ALARM  = 2'd1;
  localparam logic [1:0] SRC_ECHO   = 2'd2;
  localparam logic [1:0] SRC_REPORT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t      state_reg, state_next;
  logic        ring_d_reg;
  logic        alarm_pend_reg;
  logic        rpt_pend_reg;
  logic [7:0]  tick_cnt_reg;
  logic [3:0]  idx_reg;
  logic [1:0]  src_reg;
  logic [23:0] snap_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic        tx_en_reg;
  logic [7:0]  tx_din_reg;

  logic        echo_pend;
  logic [7:0]  echo_byte;
  logic [1:0]  grant_src;
  logic [1:0]  cur_src;
  logic [23:0] cur_time;
  logic        load_byte;
  logic [3:0]  byte_idx;
  logic [7:0]  byte_val;

  function automatic logic [7:0] digit(input logic [3:0] nib);
    return 8'h30 + {4'h0, nib};
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] s);
    case (s)
      SRC_ALARM:  return 4'd6;
      SRC_REPORT: return 4'd9;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input logic [1:0] s, input logic [3:0] i,
                                          input logic [23:0] t, input logic [7:0] eb);
    logic [7:0] b;
    b = 8'h00;
    case (s)
      SRC_ALARM: begin
        case (i)
          4'd0: b = 8'h41;
          4'd1: b = 8'h4C;
          4'd2: b = 8'h41;
          4'd3: b = 8'h52;
          4'd4: b = 8'h4D;
          4'd5: b = 8'h0D;
          default: b = 8'h0A;
        endcase
      end
      SRC_ECHO: b = eb;
      SRC_REPORT: begin
        case (i)
          4'd0: b = digit(t[23:20]);
          4'd1: b = digit(t[19:16]);
          4'd2: b = 8'h3A;
          4'd3: b = digit(t[15:12]);
          4'd4: b = digit(t[11:8]);
          4'd5: b = 8'h3A;
          4'd6: b = digit(t[7:4]);
          4'd7: b = digit(t[3:0]);
          4'd8: b = 8'h0D;
          default: b = 8'h0A;
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef TX_ECHO_EN
  logic       echo_pend_reg;
  logic [7:0] echo_buf_reg;

  // A new rx_done in the grant cycle re-arms the echo so the latest byte is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_pend_reg <= 1'b0;
      echo_buf_reg  <= 8'h00;
    end else begin
      if (state_reg == S_GRANT && grant_src == SRC_ECHO)
        echo_pend_reg <= 1'b0;
      if (rx_done) begin
        echo_pend_reg <= 1'b1;
        echo_buf_reg  <= rx_data;
      end
    end
  end

  assign echo_pend = echo_pend_reg;
  assign echo_byte = echo_buf_reg;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_done, rx_data};
  assign echo_pend = 1'b0;
  assign echo_byte = 8'h00;
`endif

  always_comb begin
    grant_src = SRC_NONE;
    if (alarm_pend_reg)    grant_src = SRC_ALARM;
    else if (echo_pend)    grant_src = SRC_ECHO;
    else if (rpt_pend_reg) grant_src = SRC_REPORT;
  end

  // In GRANT the first byte is built from the live time, which is also what gets snapshotted.
  assign cur_src  = (state_reg == S_GRANT) ? grant_src : src_reg;
  assign cur_time = (state_reg == S_GRANT) ? {hour, min, sec} : snap_reg;
  assign byte_val = msg_byte(cur_src, byte_idx, cur_time, echo_byte);

  always_comb begin
    state_next = state_reg;
    load_byte  = 1'b0;
    byte_idx   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (alarm_pend_reg || echo_pend || rpt_pend_reg)
          state_next = S_GRANT;
      end
      S_GRANT: begin
        if (grant_src == SRC_NONE) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_SEND;
          load_byte  = 1'b1;
          byte_idx   = 4'd0;
        end
      end
      S_SEND: state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tx.tx_busy || tmo_cnt_reg == TW'(BUSY_TIMEOUT - 1))
          state_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx.tx_busy) begin
          if (idx_reg == last_idx(src_reg)) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_SEND;
            load_byte  = 1'b1;
            byte_idx   = idx_reg + 4'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      ring_d_reg     <= 1'b0;
      alarm_pend_reg <= 1'b0;
      rpt_pend_reg   <= 1'b0;
      tick_cnt_reg   <= 8'd0;
      idx_reg        <= 4'd0;
      src_reg        <= SRC_NONE;
      snap_reg       <= 24'd0;
      tmo_cnt_reg    <= '0;
      tx_en_reg      <= 1'b0;
      tx_din_reg     <= 8'h00;
    end else begin
      state_reg  <= state_next;
      ring_d_reg <= ring_alarm;
      tx_en_reg  <= load_byte;

      if (state_reg == S_GRANT) begin
        src_reg  <= grant_src;
        snap_reg <= {hour, min, sec};
        if (grant_src == SRC_ALARM)  alarm_pend_reg <= 1'b0;
        if (grant_src == SRC_REPORT) rpt_pend_reg   <= 1'b0;
      end
      if (state_reg != S_IDLE && state_next == S_IDLE)
        src_reg <= SRC_NONE;

      // Request capture comes after the grant clear so a same-cycle request survives.
      if (ring_alarm && !ring_d_reg)
        alarm_pend_reg <= 1'b1;
      if (!report_en) begin
        tick_cnt_reg <= 8'd0;
        rpt_pend_reg <= 1'b0;
      end else if (clk1sec) begin
        if (tick_cnt_reg == 8'(REPORT_DIV - 1)) begin
          tick_cnt_reg <= 8'd0;
          rpt_pend_reg <= 1'b1;
        end else begin
          tick_cnt_reg <= tick_cnt_reg + 8'd1;
        end
      end

      if (state_reg == S_WAIT_HI) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      else                        tmo_cnt_reg <= '0;

      if (load_byte) begin
        tx_din_reg <= byte_val;
        idx_reg    <= byte_idx;
      end
    end
  end

  assign tx.tx_en  = tx_en_reg;
  assign tx.tx_din = tx_din_reg;
  assign msg_busy  = (state_reg != S_IDLE);
  assign src       = src_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a uart_tx busy model, a byte monitor and
// expected message queues built from the message formats.
module tb_uart_tx_scheduler;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clk1sec, report_en, ring_alarm, rx_done;
  logic [7:0] rx_data, hour, min, sec;
  logic       msg_busy;
  logic [1:0] src;

  logic       clk1sec3, report_en3, msg_busy3;
  logic [1:0] src3;

  uart_tx_scheduler_if ifc();
  uart_tx_scheduler_if ifc3();
  assign ifc3.tx_busy = 1'b0;

  uart_tx_scheduler #(.REPORT_DIV(1), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec), .report_en(report_en),
    .ring_alarm(ring_alarm), .rx_done(rx_done), .rx_data(rx_data),
    .hour(hour), .min(min), .sec(sec), .tx(ifc), .msg_busy(msg_busy), .src(src)
  );

  uart_tx_scheduler #(.REPORT_DIV(3), .BUSY_TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst), .clk1sec(clk1sec3), .report_en(report_en3),
    .ring_alarm(1'b0), .rx_done(1'b0), .rx_data(8'h00),
    .hour(hour), .min(min), .sec(sec), .tx(ifc3), .msg_busy(msg_busy3), .src(src3)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_left = 0;
  int en_while_busy = 0;
  int count3 = 0;
  logic mb3_d = 1'b0;
  logic stuck_low = 1'b0;
  logic [9:0] got_q[$];
  int         got_cyc[$];
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in: goes busy for a random number of cycles after each tx_en.
  always @(negedge clk) begin
    if (!rst) begin
      ifc.tx_busy <= 1'b0;
      busy_left   <= 0;
    end else if (ifc.tx_en && !stuck_low) begin
      ifc.tx_busy <= 1'b1;
      busy_left   <= int'($urandom_range(1, 6));
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else if (busy_left == 1) begin
      busy_left   <= 0;
      ifc.tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (ifc.tx_en) begin
      got_q.push_back({src, ifc.tx_din});
      got_cyc.push_back(cyc);
      if (ifc.tx_busy) en_while_busy <= en_while_busy + 1;
    end
    mb3_d <= msg_busy3;
    if (msg_busy3 && !mb3_d) count3 <= count3 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digit(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic void push_alarm();
    logic [7:0] a [7];
    a = '{8'h41, 8'h4C, 8'h41, 8'h52, 8'h4D, 8'h0D, 8'h0A};
    foreach (a[i]) exp_q.push_back({2'd1, a[i]});
  endfunction

  function automatic void push_report(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    logic [7:0] r [10];
    r = '{digit(h[7:4]), digit(h[3:0]), 8'h3A, digit(m[7:4]), digit(m[3:0]), 8'h3A,
          digit(s[7:4]), digit(s[3:0]), 8'h0D, 8'h0A};
    foreach (r[i]) exp_q.push_back({2'd3, r[i]});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk1sec = 1'b1;
    step();
    clk1sec = 1'b0;
  endtask

  task automatic tick3();
    clk1sec3 = 1'b1;
    step();
    clk1sec3 = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int k = 0;
    while (got_q.size() < n && k < limit) begin
      step();
      k++;
    end
    check($sformatf("wait_bytes_%0d", n), 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    int quiet = 0;
    while (quiet < 5 && k < limit) begin
      step();
      k++;
      quiet = (!msg_busy && !ifc.tx_busy) ? quiet + 1 : 0;
    end
    check("idle_reached", 32'(quiet >= 5), 32'd1);
  endtask

  task automatic compare_msgs(input string tag);
    int n;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    logic saw_busy;
    logic [7:0] ra, rb;
    int ticks_since, exp3;

    rst = 1'b0;
    clk1sec = 0; report_en = 0; ring_alarm = 0; rx_done = 0; rx_data = 8'h00;
    hour = 8'h00; min = 8'h00; sec = 8'h00;
    clk1sec3 = 0; report_en3 = 0;
    repeat (3) step();
    check("rst_tx_en", 32'(ifc.tx_en), 32'd0);
    check("rst_tx_din", 32'(ifc.tx_din), 32'd0);
    check("rst_msg_busy", 32'(msg_busy), 32'd0);
    check("rst_src", 32'(src), 32'd0);
    report_en = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    got_q.delete();
    got_cyc.delete();

    // Report of 12:34:56 with its two-cycle start latency.
    hour = 8'h12; min = 8'h34; sec = 8'h56;
    tick();
    check("t1_idle_after_tick", 32'(msg_busy), 32'd0);
    step();
    check("t1_grant_busy", 32'(msg_busy), 32'd1);
    check("t1_grant_no_en", 32'(ifc.tx_en), 32'd0);
    step();
    check("t1_first_en", 32'(ifc.tx_en), 32'd1);
    check("t1_first_din", 32'(ifc.tx_din), 32'h31);
    check("t1_src", 32'(src), 32'd3);
    wait_bytes(10, 400);
    saw_busy = 1'b0;
    for (int k = 0; k < 200 && msg_busy; k++) begin
      if (ifc.tx_busy) saw_busy = 1'b1;
      step();
    end
    check("t1_last_busy_seen", 32'(saw_busy), 32'd1);
    check("t1_end_busy_low", 32'(ifc.tx_busy), 32'd0);
    check("t1_end_msg_busy", 32'(msg_busy), 32'd0);
    push_report(8'h12, 8'h34, 8'h56);
    compare_msgs("t1");

    // Alarm edge and tick together: alarm first, report carries the time at its grant.
    ring_alarm = 1'b1;
    tick();
    wait_bytes(1, 50);
    hour = 8'($urandom); min = 8'($urandom); sec = 8'($urandom);
    wait_idle(2000);
    ring_alarm = 1'b0;
    push_alarm();
    push_report(hour, min, sec);
    compare_msgs("t2");

    // Two RX bytes during a report collapse into one echo of the later byte.
    ra = 8'($urandom);
    rb = 8'($urandom);
    tick();
    wait_bytes(2, 100);
    rx_data = ra; rx_done = 1'b1; step(); rx_done = 1'b0;
    step();
    rx_data = rb; rx_done = 1'b1; step(); rx_done = 1'b0;
    wait_idle(2000);
    push_report(hour, min, sec);
`ifdef TX_ECHO_EN
    exp_q.push_back({2'd2, rb});
`endif
    compare_msgs("t3");

    for (int r = 0; r < 3; r++) begin
      hour = 8'($urandom); min = 8'($urandom); sec = 8'($urandom);
      tick();
      wait_idle(2000);
      push_report(hour, min, sec);
      compare_msgs($sformatf("rnd%0d", r));
    end

    // Transmitter never asserts busy: every byte is released by the timeout.
    stuck_low = 1'b1;
    hour = 8'h09; min = 8'h59; sec = 8'h07;
    tick();
    wait_bytes(10, 10 * (TMO + 2) + 50);
    for (int i = 1; i < got_cyc.size(); i++)
      check($sformatf("t4_gap%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'(TMO + 2));
    wait_idle(500);
    push_report(8'h09, 8'h59, 8'h07);
    compare_msgs("t4");
    stuck_low = 1'b0;

    // Reset while the fourth report byte is in flight.
    tick();
    wait_bytes(4, 200);
    rst = 1'b0;
    step();
    check("t5_tx_en", 32'(ifc.tx_en), 32'd0);
    check("t5_tx_din", 32'(ifc.tx_din), 32'd0);
    check("t5_msg_busy", 32'(msg_busy), 32'd0);
    check("t5_src", 32'(src), 32'd0);
    rst = 1'b1;
    repeat (60) step();
    check("t5_no_residual", 32'(got_q.size()), 32'd4);
    check("t5_idle", 32'(msg_busy), 32'd0);
    got_q.delete();
    got_cyc.delete();

    // Divide-by-3 report cadence; disabling reports restarts the tick count.
    report_en3 = 1'b1;
    step();
    ticks_since = 0;
    exp3 = 0;
    for (int t = 0; t < 4; t++) begin
      tick3();
      ticks_since++;
      if (ticks_since % 3 == 0) exp3++;
      repeat (130) step();
      check($sformatf("t6_a_tick%0d", t), 32'(count3), 32'(exp3));
    end
    report_en3 = 1'b0;
    tick3();
    repeat (3) step();
    report_en3 = 1'b1;
    ticks_since = 0;
    for (int t = 0; t < 3; t++) begin
      tick3();
      ticks_since++;
      if (ticks_since % 3 == 0) exp3++;
      repeat (130) step();
      check($sformatf("t6_b_tick%0d", t), 32'(count3), 32'(exp3));
    end

    check("tx_en_while_busy", 32'(en_while_busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
